// File: rtl/rf_raddr_gen_if.sv
// Bundle between the RF read-address generator, the register file read port
// and the XNOR/popcount datapath.
interface rf_raddr_gen_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int PASS_W = 7
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] end_addr;
  logic [PASS_W-1:0] num_pass;
  logic              rf_ren;
  logic [ADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              out_final;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, base_addr, end_addr, num_pass, rf_rdata, out_ready,
    input  rf_ren, rf_raddr, out_data, out_valid, out_last, out_final,
           busy, done, err
  );

  modport slave (
    input  start, base_addr, end_addr, num_pass, rf_rdata, out_ready,
    output rf_ren, rf_raddr, out_data, out_valid, out_last, out_final,
           busy, done, err
  );
endinterface

// File: rtl/rf_raddr_gen.sv
// Sweeps [base..end] num_pass times, issues synchronous RF reads and buffers
// returned words in a 2-entry skid buffer in front of a valid/ready output.
module rf_raddr_gen #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int PASS_W = 7
) (
  input logic           clk,
  input logic           rst,
  rf_raddr_gen_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [PASS_W-1:0] np_q, np_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic                   infl_q, infl_last_q, infl_fin_q;
  logic [1:0][DATA_W-1:0] mem_q;
  logic [1:0]             lst_q, fin_q;
  logic                   rd_ptr_q, wr_ptr_q;
  logic [1:0]             occ_q;

  logic       out_valid, pop, issue, at_end, last_pass;
  logic [2:0] lvl;

  assign out_valid = (occ_q != 2'd0);
  assign pop       = out_valid & bus.out_ready;
  // Entries held or already on their way, net of this cycle's pop.
  assign lvl       = {1'b0, occ_q} + {2'b0, infl_q} - {2'b0, pop};
  assign issue     = (state_q == S_ISSUE) && (lvl < 3'd2);
  assign at_end    = (addr_q == end_q);
  assign last_pass = (pass_q == np_q - PASS_W'(1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    base_d  = base_q;
    end_d   = end_q;
    np_d    = np_q;
    pass_d  = pass_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        base_d = bus.base_addr;
        end_d  = bus.end_addr;
        np_d   = bus.num_pass;
        addr_d = bus.base_addr;
        pass_d = '0;
        err_d  = 1'b0;
        if ((bus.base_addr > bus.end_addr) || (bus.num_pass == '0)) begin
          err_d  = 1'b1;
          done_d = 1'b1;
        end else begin
          busy_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: if (issue) begin
        if (at_end) begin
          addr_d = base_q;
          pass_d = pass_q + PASS_W'(1);
          if (last_pass) state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: if (pop && fin_q[rd_ptr_q]) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      base_q  <= '0;
      end_q   <= '0;
      np_q    <= '0;
      pass_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      end_q   <= end_d;
      np_q    <= np_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Tags follow the read through the RF latency and land with the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      infl_fin_q  <= 1'b0;
      mem_q       <= '0;
      lst_q       <= '0;
      fin_q       <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      occ_q       <= '0;
    end else begin
      infl_q      <= issue;
      infl_last_q <= issue & at_end;
      infl_fin_q  <= issue & at_end & last_pass;
      if (infl_q) begin
        mem_q[wr_ptr_q] <= bus.rf_rdata;
        lst_q[wr_ptr_q] <= infl_last_q;
        fin_q[wr_ptr_q] <= infl_fin_q;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, infl_q} - {1'b0, pop};
    end
  end

  assign bus.rf_ren    = issue;
  assign bus.rf_raddr  = addr_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.out_last  = out_valid & lst_q[rd_ptr_q];
  assign bus.out_final = out_valid & fin_q[rd_ptr_q];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_rf_raddr_gen.sv
// Randomized bench for rf_raddr_gen: a queue-based job/transfer model is
// compared against the DUT every cycle, plus literal checks on fixed jobs.
module tb_rf_raddr_gen;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_raddr_gen_if #(.ADDR_W(7), .DATA_W(32), .PASS_W(7)) bus ();
  rf_raddr_gen #(.ADDR_W(7), .DATA_W(32), .PASS_W(7)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [128];
  int mode = 0;
  int ph   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Register file: data one cycle after the read enable.
  always @(posedge clk) bus.rf_rdata <= bus.rf_ren ? mem[bus.rf_raddr] : $urandom();

  initial forever begin
    @(posedge clk); #1;
    case (mode)
      0: bus.out_ready = 1'b1;
      1: begin bus.out_ready = (ph == 0) || (ph == 3); ph = (ph + 1) % 4; end
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Behavioural model: the job is a list of addresses still to read; words
  // are a FIFO of what the datapath must still see.
  typedef struct { int a; bit last; bit fin; } rd_t;
  typedef struct { logic [31:0] d; bit last; bit fin; } wd_t;
  rd_t addrq[$];
  wd_t bufq[$];
  wd_t infl_ent;
  bit  infl_m, busy_m, done_m, err_m;
  bit  exp_v, pop_m, ren_e, busy_n, done_n;
  wd_t w;

  always @(negedge clk) begin
    if (rst) begin
      addrq.delete(); bufq.delete();
      infl_m = 0; busy_m = 0; done_m = 0; err_m = 0;
    end else begin
      exp_v = (bufq.size() != 0);
      chk("busy", bus.busy, busy_m);
      chk("done", bus.done, done_m);
      chk("err", bus.err, err_m);
      chk("out_valid", bus.out_valid, exp_v);
      if (exp_v) begin
        chk("out_data", bus.out_data, bufq[0].d);
        chk("out_last", bus.out_last, bufq[0].last);
        chk("out_final", bus.out_final, bufq[0].fin);
      end
      pop_m = exp_v && bus.out_ready;
      ren_e = busy_m && (addrq.size() != 0) && (bufq.size() + int'(infl_m) - int'(pop_m) < 2);
      chk("rf_ren", bus.rf_ren, ren_e);
      if (ren_e) chk("rf_raddr", bus.rf_raddr, addrq[0].a);
      busy_n = busy_m;
      done_n = 0;
      if (pop_m) begin
        w = bufq.pop_front();
        if (w.fin) begin done_n = 1; busy_n = 0; end
      end
      if (infl_m) bufq.push_back(infl_ent);
      infl_m = ren_e;
      if (ren_e) begin
        infl_ent = '{mem[addrq[0].a], addrq[0].last, addrq[0].fin};
        void'(addrq.pop_front());
      end
      if (bus.start && !busy_m) begin
        err_m = 0;
        if (bus.base_addr > bus.end_addr || bus.num_pass == 0) begin
          err_m = 1; done_n = 1;
        end else begin
          busy_n = 1;
          for (int p = 0; p < int'(bus.num_pass); p++)
            for (int a = int'(bus.base_addr); a <= int'(bus.end_addr); a++)
              addrq.push_back('{a, a == int'(bus.end_addr),
                                (a == int'(bus.end_addr)) && (p == int'(bus.num_pass) - 1)});
        end
      end
      busy_m = busy_n;
      done_m = done_n;
    end
  end

  // Returns at cycle 1 + 1ns: the next negedge is the first issue cycle.
  task automatic start_job(input int b, input int e, input int np);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = 7'(b); bus.end_addr = 7'(e); bus.num_pass = 7'(np);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout actual=no_done expected=done", nm);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_rf_ren"}, bus.rf_ren, 0);
    chk({nm, "_rf_raddr"}, bus.rf_raddr, 0);
    chk({nm, "_out_valid"}, bus.out_valid, 0);
    chk({nm, "_out_data"}, bus.out_data, 0);
    chk({nm, "_out_last"}, bus.out_last, 0);
    chk({nm, "_out_final"}, bus.out_final, 0);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_done"}, bus.done, 0);
    chk({nm, "_err"}, bus.err, 0);
  endtask

  int lit_a [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int b, e, np;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.end_addr = '0; bus.num_pass = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = $urandom();
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Job 1: literal addresses, latency, tags and done timing.
    mode = 0;
    start_job(0, 3, 2);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c <= 8) begin
        chk("j1_ren", bus.rf_ren, 1);
        chk("j1_raddr", bus.rf_raddr, lit_a[c-1]);
      end else chk("j1_ren_off", bus.rf_ren, 0);
      if (c < 3) chk("j1_lat_valid", bus.out_valid, 0);
      if (c >= 3 && c <= 10) begin
        chk("j1_valid", bus.out_valid, 1);
        chk("j1_data", bus.out_data, mem[lit_a[c-3]]);
        chk("j1_last", bus.out_last, (c == 6) || (c == 10));
        chk("j1_final", bus.out_final, c == 10);
      end
      if (c == 11) begin
        chk("j1_done", bus.done, 1);
        chk("j1_busy", bus.busy, 0);
      end
    end
    repeat (3) @(posedge clk);

    // Back-pressure 1,0,0,1.
    mode = 1; ph = 0;
    start_job(0, 3, 2);
    wait_done("toggle");

    // Single-address range.
    mode = 2;
    start_job(5, 5, 3);
    wait_done("single");

    // Bad configurations.
    start_job(10, 4, 1);
    @(negedge clk);
    chk("bad_done", bus.done, 1);
    chk("bad_err", bus.err, 1);
    chk("bad_busy", bus.busy, 0);
    chk("bad_ren", bus.rf_ren, 0);
    repeat (3) @(negedge clk);
    chk("bad_err_hold", bus.err, 1);
    start_job(2, 6, 0);
    @(negedge clk);
    chk("np0_done", bus.done, 1);
    chk("np0_err", bus.err, 1);

    // Start while busy is ignored.
    start_job(2, 9, 2);
    chk("accept_clears_err", bus.err, 0);
    repeat (5) @(posedge clk);
    #1 bus.start = 1'b1; bus.base_addr = 7'd0; bus.end_addr = 7'd1; bus.num_pass = 7'd1;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_done("ignore_start");

    // Asynchronous reset mid-pass, then a clean restart.
    start_job(20, 40, 3);
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_all_zero("midrst");
    @(posedge clk); #1 rst = 1'b0;
    start_job(3, 6, 1);
    @(negedge clk);
    chk("restart_ren", bus.rf_ren, 1);
    chk("restart_raddr", bus.rf_raddr, 3);
    wait_done("restart");

    // Random jobs, occasionally illegal.
    for (int j = 0; j < 14; j++) begin
      mode = (j % 3 == 0) ? 0 : 2;
      b  = $urandom_range(0, 120);
      e  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 127) : b + $urandom_range(0, 7);
      np = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
      start_job(b, e, np);
      wait_done("random");
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
